pattern_scan_ctrl: RTL and testbench
====================================

// Module: pattern_scan_ctrl
// PURPOSE
//   Run controller for the serial pattern detector. It holds two programmable
//   bit patterns (A, B) and sequences a scan: arm, fill history, detect, stop.
//   It flags matches Mealy-style, counts them per pattern, and halts at a limit.
//   It sits between the serial bit source and the status/interrupt logic.
// PARAMETERS
//   PAT_LEN  3  pattern length in bits (legal range 2..8)
//   CNT_W    8  width of match counters and limit
// PORTS
//   clock       in   1        rising-edge clock
//   reset_n     in   1        synchronous reset, active low
//   cfg_we      in   1        pattern write strobe (honoured in IDLE only)
//   cfg_sel     in   1        0 = pattern A, 1 = pattern B
//   cfg_pat     in   PAT_LEN  pattern value; MSB = oldest bit
//   limit       in   CNT_W    stop count; 0 = unlimited
//   start       in   1        begin scan (IDLE or DONE)
//   stop        in   1        abort scan (FILL or RUN)
//   bit_valid   in   1        bit_in is valid this cycle
//   bit_in      in   1        serial data bit
//   match       out  2        [1] = A matched, [0] = B matched, combinational
//   count_a     out  CNT_W    A match count
//   count_b     out  CNT_W    B match count
//   busy        out  1        high in FILL or RUN
//   done        out  1        high in DONE
// BEHAVIOUR
//   Reset (reset_n=0 at edge): state IDLE; pat_a = alternating ...101 (LSB=1);
//     pat_b = ~pat_a; history, fill count, count_a and count_b = 0.
//     All outputs are 0 after reset.
//   FSM states: IDLE, FILL, RUN, DONE. Encoding is free.
//   IDLE: cfg_we writes the selected pattern. start -> FILL; the same edge
//     clears history, fill count and both counters.
//   FILL: each valid bit shifts into the history (hist <= {hist, bit_in}).
//     match is held at 0. The edge that takes the (PAT_LEN-1)th valid bit
//     moves to RUN, so no match comes from stale or reset history.
//   RUN: win = {hist[PAT_LEN-2:0], bit_in}.
//     match[1] = bit_valid & (win == pat_a).
//     match[0] = bit_valid & (win == pat_b).
//     match is valid in the same cycle as the bit, before the edge.
//     Overlapping matches count. A and B may both match if the patterns are equal.
//     On the edge, each matched counter increments and saturates at all-ones.
//     If limit != 0 and either counter reaches limit on this edge -> DONE.
//   DONE: history frozen, bits ignored, match = 0. start -> FILL (full clear).
//   stop in FILL or RUN: -> IDLE next edge. That cycle's bit is discarded,
//     match = 0, counts are kept. stop in IDLE or DONE is a no-op.
//   start and stop in the same cycle: stop wins. start in FILL or RUN is ignored.
//   cfg_we outside IDLE is ignored; patterns change only in IDLE.
//   bit_valid = 0: no shift, no count, match = 0, no state change (except stop).
//   Reset mid-scan overrides everything and returns to the reset state.
//   Latency: match is 0-cycle (Mealy); counts, busy and done update 1 edge later.
// TESTING
//   1 Defaults, limit=0, start, then bits 0110101011 -> match=10 on bits
//     5,7,9 and 01 on bits 6,8; final count_a=3, count_b=2, busy stays 1.
//   2 Same stream, limit=2 -> DONE after bit 7; count_a=2, count_b=1;
//     bits 8..10 give match=0; done=1, busy=0.
//   3 IDLE: write A=3'b111, B=3'b000; stream 1111000 -> count_a=2, count_b=1.
//     cfg_we while busy leaves the patterns unchanged.
//   4 stop with a matching bit in RUN -> match=0, counts held, IDLE next
//     cycle; start+stop together in IDLE -> stays IDLE.
//   5 reset_n=0 mid-RUN -> next cycle: IDLE, counts 0, default patterns;
//     bit_valid gaps in RUN -> no shift, no match.
//   6 count_a at all-ones with limit=0 and a further A match -> stays all-ones.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Run controller for the serial pattern detector: holds two programmable
// patterns, sequences arm/fill/detect/stop, flags and counts matches per pattern.
module pattern_scan_ctrl #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [PAT_LEN-1:0] cfg_pat,
    input  logic [CNT_W-1:0]   limit,
    input  logic               start,
    input  logic               stop,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic [1:0]         match,
    output logic [CNT_W-1:0]   count_a,
    output logic [CNT_W-1:0]   count_b,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam int HIST_W = PAT_LEN - 1;
    localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN - 1) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 2);

    // Alternating pattern with the LSB set: ...0101.
    function automatic logic [PAT_LEN-1:0] alt_pat();
        logic [PAT_LEN-1:0] p;
        for (int i = 0; i < PAT_LEN; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction

    localparam logic [PAT_LEN-1:0] PAT_RESET = alt_pat();

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    logic [PAT_LEN-1:0] pat_a;
    logic [PAT_LEN-1:0] pat_b;
    logic [HIST_W-1:0]  hist;
    logic [FILL_W-1:0]  fill_cnt;

    logic [PAT_LEN-1:0] win;
    logic               hit_a;
    logic               hit_b;
    logic [CNT_W-1:0]   next_a;
    logic [CNT_W-1:0]   next_b;
    logic               limit_hit;
    logic               take_start;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        win        = {hist, bit_in};
        hit_a      = (state == RUN) && bit_valid && !stop && (win == pat_a);
        hit_b      = (state == RUN) && bit_valid && !stop && (win == pat_b);
        next_a     = hit_a ? sat_inc(count_a) : count_a;
        next_b     = hit_b ? sat_inc(count_b) : count_b;
        limit_hit  = (limit != '0) &&
                     ((hit_a && next_a == limit) || (hit_b && next_b == limit));
        take_start = start && !stop;
        match      = {hit_a, hit_b};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            pat_a    <= PAT_RESET;
            pat_b    <= ~PAT_RESET;
            hist     <= '0;
            fill_cnt <= '0;
            count_a  <= '0;
            count_b  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_sel) pat_b <= cfg_pat;
                        else         pat_a <= cfg_pat;
                    end
                    if (take_start) begin
                        state    <= FILL;
                        hist     <= '0;
                        fill_cnt <= '0;
                        count_a  <= '0;
                        count_b  <= '0;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        hist <= win[HIST_W-1:0];
                        if (fill_cnt == FILL_LAST) state <= RUN;
                        else                       fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        hist    <= win[HIST_W-1:0];
                        count_a <= next_a;
                        count_b <= next_b;
                        if (limit_hit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // History stays frozen; only a fresh start leaves DONE.
                    if (take_start) begin
                        state    <= FILL;
                        hist     <= '0;
                        fill_cnt <= '0;
                        count_a  <= '0;
                        count_b  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: stimulus queues expected match values,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_pattern_scan_ctrl;

    localparam int PAT_LEN = 3;
    localparam int CNT_W   = 8;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               cfg_we;
    logic               cfg_sel;
    logic [PAT_LEN-1:0] cfg_pat;
    logic [CNT_W-1:0]   limit;
    logic               start;
    logic               stop;
    logic               bit_valid;
    logic               bit_in;
    logic [1:0]         match;
    logic [CNT_W-1:0]   count_a;
    logic [CNT_W-1:0]   count_b;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

    typedef struct {
        logic [1:0] m;
        int         idx;
    } exp_t;

    exp_t exp_q[$];

    pattern_scan_ctrl #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_pat   (cfg_pat),
        .limit     (limit),
        .start     (start),
        .stop      (stop),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .match     (match),
        .count_a   (count_a),
        .count_b   (count_b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each queued entry covers exactly one driven cycle.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("match[%0d]", e.idx), 32'(match), 32'(e.m));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic st, input logic sp,
                         input logic [1:0] em);
        exp_t e;
        bit_valid = v;
        bit_in    = b;
        start     = st;
        stop      = sp;
        e.m       = em;
        e.idx     = vec_idx++;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Bit k (1-based) of the stream is bits[n-k]; ea/eb hold expected A/B flags.
    task automatic stream(input logic [15:0] bits, input logic [15:0] ea,
                          input logic [15:0] eb, input int n);
        for (int k = 1; k <= n; k++)
            drive(1'b1, bits[n-k], 1'b0, 1'b0, {ea[n-k], eb[n-k]});
        bit_valid = 1'b0;
    endtask

    task automatic write_pat(input logic sel, input logic [PAT_LEN-1:0] p);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_pat = p;
        idle();
        cfg_we  = 1'b0;
    endtask

    task automatic status(input string tag, input logic [CNT_W-1:0] ea, input logic [CNT_W-1:0] eb,
                          input logic eb_busy, input logic eb_done);
        check({tag, " count_a"}, 32'(count_a), 32'(ea));
        check({tag, " count_b"}, 32'(count_b), 32'(eb));
        check({tag, " busy"},    32'(busy),    32'(eb_busy));
        check({tag, " done"},    32'(done),    32'(eb_done));
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_pat = '0; limit = '0;
        start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        status("reset", 8'd0, 8'd0, 1'b0, 1'b0);
        check("reset match", 32'(match), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);   // IDLE bits never match

        // 1: default patterns A=101, B=010, unlimited
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        check("t1 busy after start", 32'(busy), 32'd1);
        stream(16'b0110101011, 16'b0000101010, 16'b0000010100, 10);
        status("t1", 8'd3, 8'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);

        // 2: same stream, limit=2 stops after bit 7
        limit = 8'd2;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b0110101011, 16'b0000101000, 16'b0000010000, 10);
        status("t2", 8'd2, 8'd1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);   // start from DONE clears
        status("t2 restart", 8'd0, 8'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        limit = 8'd0;

        // 3: programmed patterns, and writes while busy are ignored
        write_pat(1'b0, 3'b111);
        write_pat(1'b1, 3'b000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b1111000, 16'b0011000, 16'b0000001, 7);
        status("t3", 8'd2, 8'd1, 1'b1, 1'b0);
        write_pat(1'b0, 3'b010);
        write_pat(1'b1, 3'b101);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b111000, 16'b001000, 16'b000001, 6);
        status("t3 pats kept", 8'd1, 8'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);

        // 4: stop on a matching bit, then start+stop in IDLE
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b111, 16'b001, 16'b000, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        status("t4 stop", 8'd1, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        status("t4 start+stop", 8'd1, 8'd0, 1'b0, 1'b0);

        // 5: bit_valid gaps do not shift; reset mid-RUN restores defaults
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b111, 16'b001, 16'b000, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        status("t5 gaps", 8'd2, 8'd0, 1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        status("t5 reset", 8'd0, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        stream(16'b0110101011, 16'b0000101010, 16'b0000010100, 10);
        status("t5 defaults", 8'd3, 8'd2, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);

        // 6: count_a saturates at all-ones with limit=0
        write_pat(1'b0, 3'b111);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 255; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        status("t6 at max", 8'hff, 8'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        status("t6 saturated", 8'hff, 8'd0, 1'b1, 1'b0);
        idle();

        @(negedge clock);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
